// File: rtl/gate_array_pkg.sv
// Shared definitions for the gate array: gate mode codes and the per-bit gate function.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
package gate_array_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_NOR  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_NAND = 3'd1;
    localparam logic [MODE_W-1:0] MODE_AND  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;
    localparam logic [MODE_W-1:0] MODE_NOTA = 3'd6;
    localparam logic [MODE_W-1:0] MODE_BUF  = 3'd7;

    // Every 3-bit code maps to a gate, so there is no illegal-mode handling.
    function automatic logic gate_func(
        input logic [MODE_W-1:0] i_mode,
        input logic              i_a,
        input logic              i_b
    );
        logic w_res;
        case (i_mode)
            MODE_NOR:  w_res = ~(i_a | i_b);
            MODE_NAND: w_res = ~(i_a & i_b);
            MODE_AND:  w_res = i_a & i_b;
            MODE_OR:   w_res = i_a | i_b;
            MODE_XOR:  w_res = i_a ^ i_b;
            MODE_XNOR: w_res = ~(i_a ^ i_b);
            MODE_NOTA: w_res = ~i_a;
            default:   w_res = i_a;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/gate_array_cfg_in_filter.sv
// One asynchronous input bit: synchroniser chain followed by a consecutive-cycle debounce filter.
// Latency: SYNC_STAGES edges to the synchronised value, plus DEB_CYCLES edges of stable difference to flip o_f.
// Backpressure: none; samples every clock edge.
module in_filter
    import gate_array_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_f
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    // Shift the raw pin through the synchroniser chain; stage 0 is the metastability catcher.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            // No filtering: the synchronised value feeds the gate directly.
            assign o_f = w_s;
        end else begin : g_debounce
            localparam int CW = $clog2(DEB_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_f;

            // Count consecutive edges where the input disagrees with the filtered value;
            // any agreeing edge restarts the count so short glitches never reach o_f.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_f   <= 1'b0;
                end else if (w_s != r_f) begin
                    if (r_cnt == CNT_LAST) begin
                        r_f   <= w_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end

            assign o_f = r_f;
        end
    endgenerate

endmodule

// File: rtl/gate_array_cfg.sv
// Multi-channel 2-input gate array with filtered inputs, runtime gate mode and registered outputs.
// Latency: raw input change to y is SYNC_STAGES + DEB_CYCLES + 1 edges; mode load to y is 1 edge later.
// Backpressure: none; outputs update every edge, y_chg flags each channel whose y changed.
module gate_array_cfg
    import gate_array_pkg::*;
#(
    parameter int                NCH         = 4,
    parameter int                SYNC_STAGES = 2,
    parameter int                DEB_CYCLES  = 4,
    parameter logic [MODE_W-1:0] MODE_RST    = MODE_NOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    a,
    input  logic [NCH-1:0]    b,
    input  logic [MODE_W-1:0] mode_in,
    input  logic              mode_load,
    input  logic              en,
    output logic [NCH-1:0]    y,
    output logic [NCH-1:0]    y_chg,
    output logic              y_en,
    output logic [MODE_W-1:0] mode
);

    // Value every channel shows while in reset: the reset-mode gate applied to two zero inputs.
    localparam logic Y_RST_BIT = gate_func(MODE_RST, 1'b0, 1'b0);

    logic [2*NCH-1:0]  w_raw;
    logic [2*NCH-1:0]  w_filt;
    logic [NCH-1:0]    w_fa;
    logic [NCH-1:0]    w_fb;
    logic [NCH-1:0]    w_y_next;

    logic [MODE_W-1:0] r_mode;
    logic [NCH-1:0]    r_y;
    logic [NCH-1:0]    r_y_chg;
    logic              r_y_en;

    // A bits occupy the low half, B bits the high half, so one loop filters both.
    assign w_raw = {b, a};

    generate
        for (genvar gi = 0; gi < 2 * NCH; gi++) begin : g_in
            in_filter #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEB_CYCLES  (DEB_CYCLES)
            ) u_in_filter (
                .clk (clk),
                .rst (rst),
                .i_d (w_raw[gi]),
                .o_f (w_filt[gi])
            );
        end
    endgenerate

    assign w_fa = w_filt[NCH-1:0];
    assign w_fb = w_filt[2*NCH-1:NCH];

    // Apply the currently registered mode to every channel's filtered pair.
    always_comb begin
        w_y_next = '0;
        for (int i = 0; i < NCH; i++) begin
            w_y_next[i] = gate_func(r_mode, w_fa[i], w_fb[i]);
        end
    end

    // Mode register: a load takes effect on y one edge after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_RST;
        end else if (mode_load) begin
            r_mode <= mode_in;
        end
    end

    // Output register, change pulse (input- or mode-induced) and registered enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= {NCH{Y_RST_BIT}};
            r_y_chg <= '0;
            r_y_en  <= 1'b0;
        end else begin
            r_y     <= w_y_next;
            r_y_chg <= w_y_next ^ r_y;
            r_y_en  <= en;
        end
    end

    assign y     = r_y;
    assign y_chg = r_y_chg;
    assign y_en  = r_y_en;
    assign mode  = r_mode;

endmodule
